// File: rtl/noc_router_credit.sv
// +--------------------------------------------------------------------------+
// | Module  : noc_router_credit                                              |
// | Brief   : 5-port XY mesh router, input FIFOs, round-robin output         |
// |           arbitration, credit-based flow control toward downstream.      |
// |           Define ROUTER_ERR_EN to add sticky err_ovf flags.              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module noc_router_credit #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4,
    parameter int ID_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ID_W-1:0]            ID,
    input  logic [5*(DATA_W+1)-1:0]    indata,
    output logic [5*(DATA_W+1)-1:0]    outdata,
    input  logic [4:0]                 credit_in,
    output logic [4:0]                 credit_out
`ifdef ROUTER_ERR_EN
    ,
    output logic [4:0]                 err_ovf
`endif
);

    localparam int c_NP = 5;
    localparam int c_SW = DATA_W + 1;
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_HW = ID_W / 2;

    localparam logic [c_CW-1:0] c_FULL   = c_CW'(DEPTH);
    localparam logic [2:0]      c_PORT_P = 3'd0;
    localparam logic [2:0]      c_PORT_E = 3'd1;
    localparam logic [2:0]      c_PORT_S = 3'd2;
    localparam logic [2:0]      c_PORT_W = 3'd3;
    localparam logic [2:0]      c_PORT_N = 3'd4;
    localparam logic [2:0]      c_RR_RST = 3'd4;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [2:0] xy_route(input logic [ID_W-1:0] dst,
                                            input logic [ID_W-1:0] me);
        logic [c_HW-1:0] dx;
        logic [c_HW-1:0] dy;
        logic [c_HW-1:0] x;
        logic [c_HW-1:0] y;
        dx = dst[c_HW-1:0];
        dy = dst[ID_W-1:c_HW];
        x  = me[c_HW-1:0];
        y  = me[ID_W-1:c_HW];
        if (dx > x)      return c_PORT_E;
        else if (dx < x) return c_PORT_W;
        else if (dy > y) return c_PORT_S;
        else if (dy < y) return c_PORT_N;
        else             return c_PORT_P;
    endfunction

    function automatic logic [2:0] rr_next(input logic [2:0] base,
                                           input logic [2:0] step);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 4'd5) sum = sum - 4'd5;
        return sum[2:0];
    endfunction

    // ------------------------------------------------------------------
    // Input slot unpacking
    // ------------------------------------------------------------------
    logic [c_NP-1:0]   w_in_vld;
    logic [DATA_W-1:0] w_in_pay [c_NP];

    generate
        for (genvar g = 0; g < c_NP; g++) begin : g_unpack
            assign w_in_vld[g] = indata[g*c_SW + DATA_W];
            assign w_in_pay[g] = indata[g*c_SW +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q    [c_NP][DEPTH];
    logic [DATA_W-1:0] mem_d    [c_NP][DEPTH];
    logic [c_AW-1:0]   wr_ptr_q [c_NP];
    logic [c_AW-1:0]   wr_ptr_d [c_NP];
    logic [c_AW-1:0]   rd_ptr_q [c_NP];
    logic [c_AW-1:0]   rd_ptr_d [c_NP];
    logic [c_CW-1:0]   fill_q   [c_NP];
    logic [c_CW-1:0]   fill_d   [c_NP];
    logic [c_CW-1:0]   crd_q    [c_NP];
    logic [c_CW-1:0]   crd_d    [c_NP];
    logic [2:0]        rr_q     [c_NP];
    logic [2:0]        rr_d     [c_NP];
    logic [5*c_SW-1:0] outdata_q;
    logic [5*c_SW-1:0] outdata_d;
    logic [c_NP-1:0]   credit_out_q;
    logic [c_NP-1:0]   credit_out_d;

    // ------------------------------------------------------------------
    // FIFO heads and their XY requests
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_head  [c_NP];
    logic [2:0]        w_route [c_NP];
    logic [c_NP-1:0]   w_empty;
    logic [c_NP-1:0]   w_full;

    always_comb begin
        for (int i = 0; i < c_NP; i++) begin
            w_head[i]  = mem_q[i][rd_ptr_q[i]];
            w_route[i] = xy_route(w_head[i][DATA_W-1 -: ID_W], ID);
            w_empty[i] = (fill_q[i] == '0);
            w_full[i]  = (fill_q[i] == c_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Per-output round-robin arbitration, gated by downstream credit
    // ------------------------------------------------------------------
    logic [c_NP-1:0] w_gnt;
    logic [2:0]      w_gnt_idx [c_NP];
    logic [c_NP-1:0] w_pop;
    logic [2:0]      w_cand;

    always_comb begin
        w_cand = '0;
        for (int o = 0; o < c_NP; o++) begin
            w_gnt[o]     = 1'b0;
            w_gnt_idx[o] = '0;
            for (int k = 1; k <= c_NP; k++) begin
                w_cand = rr_next(rr_q[o], 3'(k));
                if (!w_gnt[o] && (crd_q[o] != '0) && !w_empty[w_cand] &&
                    (w_route[w_cand] == 3'(o))) begin
                    w_gnt[o]     = 1'b1;
                    w_gnt_idx[o] = w_cand;
                end
            end
        end
        for (int i = 0; i < c_NP; i++) begin
            w_pop[i] = 1'b0;
            for (int o = 0; o < c_NP; o++) begin
                if (w_gnt[o] && (w_gnt_idx[o] == 3'(i))) w_pop[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO next state; a full FIFO still accepts when it pops this cycle
    // ------------------------------------------------------------------
    logic [c_NP-1:0] w_push;

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < c_NP; i++) begin
            w_push[i]   = w_in_vld[i] && (!w_full[i] || w_pop[i]);
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (w_push[i]) begin
                mem_d[i][wr_ptr_q[i]] = w_in_pay[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
            end
            if (w_pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            fill_d[i] = fill_q[i] + c_CW'(w_push[i]) - c_CW'(w_pop[i]);
        end
    end

    // ------------------------------------------------------------------
    // Credits, RR pointers and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        outdata_d    = '0;
        credit_out_d = w_pop;
        for (int o = 0; o < c_NP; o++) begin
            crd_d[o] = crd_q[o];
            rr_d[o]  = rr_q[o];
            if (w_gnt[o]) begin
                outdata_d[o*c_SW +: c_SW] = {1'b1, w_head[w_gnt_idx[o]]};
                rr_d[o]                   = w_gnt_idx[o];
            end
            // A returned credit in the same cycle as a grant cancels out
            if (w_gnt[o] && !credit_in[o]) begin
                crd_d[o] = crd_q[o] - 1'b1;
            end else if (!w_gnt[o] && credit_in[o] && (crd_q[o] != c_FULL)) begin
                crd_d[o] = crd_q[o] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NP; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                fill_q[i]   <= '0;
                crd_q[i]    <= c_FULL;
                rr_q[i]     <= c_RR_RST;
            end
            outdata_q    <= '0;
            credit_out_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            crd_q        <= crd_d;
            rr_q         <= rr_d;
            outdata_q    <= outdata_d;
            credit_out_q <= credit_out_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign outdata    = outdata_q;
    assign credit_out = credit_out_q;

`ifdef ROUTER_ERR_EN
    // ------------------------------------------------------------------
    // Sticky error flags: dropped flit or credit returned at saturation
    // ------------------------------------------------------------------
    logic [c_NP-1:0] w_drop;
    logic [c_NP-1:0] w_sat;
    logic [c_NP-1:0] err_q;
    logic [c_NP-1:0] err_d;

    always_comb begin
        for (int i = 0; i < c_NP; i++) begin
            w_drop[i] = w_in_vld[i] && w_full[i] && !w_pop[i];
            w_sat[i]  = credit_in[i] && !w_gnt[i] && (crd_q[i] == c_FULL);
        end
        err_d = err_q | w_drop | w_sat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err_ovf = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_router_credit.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_noc_router_credit                                           |
// | Brief   : Directed vector bench for noc_router_credit (ID=5, DEPTH=4).   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_noc_router_credit;

    localparam int c_BW = 65;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      id = 4'h5;
    logic [c_BW-1:0] indata;
    logic [c_BW-1:0] outdata;
    logic [4:0]      credit_in;
    logic [4:0]      credit_out;
`ifdef ROUTER_ERR_EN
    logic [4:0]      err_ovf;
`endif

    noc_router_credit #(
        .DATA_W (12),
        .DEPTH  (4),
        .ID_W   (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ID         (id),
        .indata     (indata),
        .outdata    (outdata),
        .credit_in  (credit_in),
        .credit_out (credit_out)
`ifdef ROUTER_ERR_EN
        ,
        .err_ovf    (err_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [c_BW-1:0] din;
        logic [4:0]      cin;
        logic            rstn;
        logic [c_BW-1:0] eout;
        logic [4:0]      ecout;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // One valid flit placed in slot 'port'
    function automatic logic [c_BW-1:0] fl(input int port, input logic [11:0] pay);
        logic [c_BW-1:0] v;
        v = '0;
        v[port*13 +: 13] = {1'b1, pay};
        return v;
    endfunction

    task automatic add(input logic [c_BW-1:0] din, input logic [4:0] cin,
                       input logic rstn, input logic [c_BW-1:0] eout,
                       input logic [4:0] ecout);
        vec_t v;
        v.din = din; v.cin = cin; v.rstn = rstn; v.eout = eout; v.ecout = ecout;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [c_BW-1:0] din, input logic [4:0] cin,
                        input logic rstn, input logic [c_BW-1:0] eout,
                        input logic [4:0] ecout, input string nm);
        indata    = din;
        credit_in = cin;
        rst_n     = rstn;
        @(posedge clk);
        #1;
        n_vec++;
        if (outdata !== eout) begin
            n_bad++;
            $display("FAIL %s outdata got %h want %h", nm, outdata, eout);
        end
        if (credit_out !== ecout) begin
            n_bad++;
            $display("FAIL %s credit_out got %b want %b", nm, credit_out, ecout);
        end
    endtask

`ifdef ROUTER_ERR_EN
    task automatic chk_err(input logic [4:0] e, input string nm);
        n_vec++;
        if (err_ovf !== e) begin
            n_bad++;
            $display("FAIL %s err_ovf got %b want %b", nm, err_ovf, e);
        end
    endtask
`endif

    localparam logic [c_BW-1:0] c_Z = '0;

    initial begin
        indata    = '0;
        credit_in = '0;
        rst_n     = 1'b0;

        // Reset, single flit p->e, four-way routing, credit return/saturation,
        // and round-robin contention on output s.
        add(c_Z, 5'b00000, 1'b0, c_Z, 5'b00000);
        add(c_Z, 5'b00000, 1'b0, c_Z, 5'b00000);
        add(fl(0, 12'h6AB), 5'b00000, 1'b1, c_Z, 5'b00000);
        add(c_Z, 5'b00000, 1'b1, fl(1, 12'h6AB), 5'b00001);
        add(fl(1, 12'h4A1) | fl(4, 12'h9B2) | fl(2, 12'h1C3) | fl(3, 12'h5D4),
            5'b00000, 1'b1, c_Z, 5'b00000);
        add(c_Z, 5'b00000, 1'b1,
            fl(3, 12'h4A1) | fl(2, 12'h9B2) | fl(4, 12'h1C3) | fl(0, 12'h5D4),
            5'b11110);
        add(c_Z, 5'b11111, 1'b1, c_Z, 5'b00000);
        add(c_Z, 5'b00001, 1'b1, c_Z, 5'b00000);
        add(fl(0, 12'h9E0) | fl(1, 12'h9E1), 5'b00000, 1'b1, c_Z, 5'b00000);
        add(c_Z, 5'b00000, 1'b1, fl(2, 12'h9E0), 5'b00001);
        add(fl(0, 12'h9E2) | fl(3, 12'h9E3), 5'b00000, 1'b1, fl(2, 12'h9E1), 5'b00010);
        add(c_Z, 5'b00000, 1'b1, fl(2, 12'h9E3), 5'b01000);
        add(c_Z, 5'b00000, 1'b1, fl(2, 12'h9E2), 5'b00001);
        add(c_Z, 5'b00000, 1'b1, c_Z, 5'b00000);

        foreach (tbl[i])
            step(tbl[i].din, tbl[i].cin, tbl[i].rstn, tbl[i].eout, tbl[i].ecout,
                 $sformatf("tbl%0d", i));
`ifdef ROUTER_ERR_EN
        chk_err(5'b00001, "sat_err");
`endif

        // Contention on e with one credit pre-spent; 4th flit waits for credit
        step(c_Z, 5'b0, 1'b0, c_Z, 5'b0, "a_rst");
`ifdef ROUTER_ERR_EN
        chk_err(5'b00000, "a_err_rst");
`endif
        step(fl(4, 12'h6A0), 5'b0, 1'b1, c_Z, 5'b0, "a0");
        step(c_Z, 5'b0, 1'b1, fl(1, 12'h6A0), 5'b10000, "a1");
        step(fl(0, 12'h601) | fl(1, 12'h602) | fl(2, 12'h603), 5'b0, 1'b1, c_Z, 5'b0, "a2");
        step(fl(0, 12'h604), 5'b0, 1'b1, fl(1, 12'h601), 5'b00001, "a3");
        step(c_Z, 5'b0, 1'b1, fl(1, 12'h602), 5'b00010, "a4");
        step(c_Z, 5'b0, 1'b1, fl(1, 12'h603), 5'b00100, "a5");
        step(c_Z, 5'b0, 1'b1, c_Z, 5'b0, "a6_held");
        step(c_Z, 5'b0, 1'b1, c_Z, 5'b0, "a7_held");
        step(c_Z, 5'b00010, 1'b1, c_Z, 5'b0, "a8_credit");
        step(c_Z, 5'b0, 1'b1, fl(1, 12'h604), 5'b00001, "a9_release");
        step(c_Z, 5'b0, 1'b1, c_Z, 5'b0, "a10");

        // Drain e's credits, then overfill input n; 5th flit is dropped
        step(c_Z, 5'b0, 1'b0, c_Z, 5'b0, "b_rst");
        step(fl(0, 12'h6B0), 5'b0, 1'b1, c_Z, 5'b0, "b0");
        step(fl(0, 12'h6B1), 5'b0, 1'b1, fl(1, 12'h6B0), 5'b00001, "b1");
        step(fl(0, 12'h6B2), 5'b0, 1'b1, fl(1, 12'h6B1), 5'b00001, "b2");
        step(fl(0, 12'h6B3), 5'b0, 1'b1, fl(1, 12'h6B2), 5'b00001, "b3");
        step(fl(4, 12'h6C0), 5'b0, 1'b1, fl(1, 12'h6B3), 5'b00001, "b4");
        step(fl(4, 12'h6C1), 5'b0, 1'b1, c_Z, 5'b0, "b5");
        step(fl(4, 12'h6C2), 5'b0, 1'b1, c_Z, 5'b0, "b6");
        step(fl(4, 12'h6C3), 5'b0, 1'b1, c_Z, 5'b0, "b7");
        step(fl(4, 12'h6C4), 5'b0, 1'b1, c_Z, 5'b0, "b8_drop");
        step(c_Z, 5'b00010, 1'b1, c_Z, 5'b0, "b9");
        step(c_Z, 5'b00010, 1'b1, fl(1, 12'h6C0), 5'b10000, "b10");
        step(c_Z, 5'b00010, 1'b1, fl(1, 12'h6C1), 5'b10000, "b11");
        step(c_Z, 5'b00010, 1'b1, fl(1, 12'h6C2), 5'b10000, "b12");
        step(c_Z, 5'b0, 1'b1, fl(1, 12'h6C3), 5'b10000, "b13");
        step(c_Z, 5'b0, 1'b1, c_Z, 5'b0, "b14_no5th");
        step(c_Z, 5'b0, 1'b1, c_Z, 5'b0, "b15_no5th");
`ifdef ROUTER_ERR_EN
        chk_err(5'b10000, "b_err_drop");
`endif

        // Buffer 3 flits (e has no credit), reset, then fresh traffic
        step(fl(4, 12'h6D0), 5'b0, 1'b1, c_Z, 5'b0, "c0");
        step(fl(4, 12'h6D1), 5'b0, 1'b1, c_Z, 5'b0, "c1");
        step(fl(4, 12'h6D2), 5'b0, 1'b1, c_Z, 5'b0, "c2");
        step(c_Z, 5'b0, 1'b0, c_Z, 5'b0, "c3_rst");
`ifdef ROUTER_ERR_EN
        chk_err(5'b00000, "c_err_rst");
`endif
        step(c_Z, 5'b0, 1'b1, c_Z, 5'b0, "c4");
        step(c_Z, 5'b0, 1'b1, c_Z, 5'b0, "c5");
        step(fl(0, 12'h6E0), 5'b0, 1'b1, c_Z, 5'b0, "c6");
        step(fl(0, 12'h6E1), 5'b0, 1'b1, fl(1, 12'h6E0), 5'b00001, "c7");
        step(fl(0, 12'h6E2), 5'b0, 1'b1, fl(1, 12'h6E1), 5'b00001, "c8");
        step(fl(0, 12'h6E3), 5'b0, 1'b1, fl(1, 12'h6E2), 5'b00001, "c9");
        step(fl(0, 12'h6E4), 5'b0, 1'b1, fl(1, 12'h6E3), 5'b00001, "c10");
        step(c_Z, 5'b0, 1'b1, c_Z, 5'b0, "c11_credits4");
        step(c_Z, 5'b0, 1'b1, c_Z, 5'b0, "c12_credits4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
